// File: rtl/fifo_sc_ew_req_reg_based_core_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sc_ew_req_reg_based_core_pkg
// Shared helpers for the register-based single-clock FIFO core.
//   func_log2 : ceil(log2(value)), usable in constant (parameter) context.
//   SIZE_MIN  : smallest supported FIFO depth.
// -----------------------------------------------------------------------------
package fifo_sc_ew_req_reg_based_core_pkg;

   localparam int SIZE_MIN = 2;

   // Smallest r such that (1 << r) >= value. Fixed loop bound keeps it
   // elaboration-friendly for any tool.
   function automatic int func_log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_sc_ew_req_reg_based_core.sv
// -----------------------------------------------------------------------------
// fifo_sc_ew_req_reg_based_core
// Single-clock FIFO built from SIZE flat registers, with write/read pointers
// and an occupancy counter. Any SIZE >= 2 is supported (not only powers of 2).
//
// Ports
//   clk       in   1          sole clock, rising edge
//   rstn      in   1          synchronous reset, active HIGH (name is historic)
//   wr_val_i  in   1          write request, data pushed on this edge
//   wr_dat_i  in   DATA_WD    write data
//   wr_ful_o  out  1          full flag (combinational from count)
//   rd_val_i  in   1          read request, head popped on this edge
//   rd_val_o  out  1          read response valid, rd_val_i delayed one cycle
//   rd_dat_o  out  DATA_WD    read data, registered, holds when no pop
//   rd_ept_o  out  1          empty flag (combinational from count)
//   wd_usd_o  out  SIZE_WD+1  number of stored entries, 0..SIZE
//
// Handshake: a request is issued by holding *_val_i high for one cycle; there
// is no ready back-pressure. A write is accepted unless the FIFO is full with
// no read on the same edge; a read is accepted unless the FIFO is empty.
// rd_val_o echoes every read request, accepted or not; a rejected read leaves
// rd_dat_o at its previous value.
// -----------------------------------------------------------------------------
module fifo_sc_ew_req_reg_based_core
   import fifo_sc_ew_req_reg_based_core_pkg::*;
#(
   parameter  int SIZE    = 8,
   parameter  int DATA_WD = 32,
   localparam int SIZE_WD = func_log2(SIZE)
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               wr_val_i,
   input  logic [DATA_WD-1:0] wr_dat_i,
   output logic               wr_ful_o,
   input  logic               rd_val_i,
   output logic               rd_val_o,
   output logic [DATA_WD-1:0] rd_dat_o,
   output logic               rd_ept_o,
   output logic [SIZE_WD:0]   wd_usd_o
);

   localparam logic [SIZE_WD-1:0] PTR_LAST = SIZE_WD'(SIZE - 1);
   localparam logic [SIZE_WD-1:0] PTR_ONE  = SIZE_WD'(1);
   localparam logic [SIZE_WD:0]   CNT_FULL = (SIZE_WD + 1)'(SIZE);
   localparam logic [SIZE_WD:0]   CNT_ONE  = (SIZE_WD + 1)'(1);

   logic [DATA_WD-1:0] r_mem [SIZE];
   logic [SIZE_WD-1:0] r_wr_ptr;
   logic [SIZE_WD-1:0] r_rd_ptr;
   logic [SIZE_WD:0]   r_cnt;
   logic               r_rd_val;
   logic [DATA_WD-1:0] r_rd_dat;

   logic w_full;
   logic w_empty;
   logic w_wr_acc;
   logic w_rd_acc;

   // One wrap rule for both pointers; explicit compare so non-power-of-two
   // depths wrap from SIZE-1 back to 0.
   function automatic logic [SIZE_WD-1:0] ptr_inc(input logic [SIZE_WD-1:0] p);
      if (p == PTR_LAST) return '0;
      return p + PTR_ONE;
   endfunction

   assign w_full   = (r_cnt >= CNT_FULL);
   assign w_empty  = (r_cnt == '0);
   assign w_rd_acc = rd_val_i && !w_empty;
   // When full, a same-edge read frees the head slot, which is exactly the
   // slot the write pointer addresses; the read samples the old value first.
   assign w_wr_acc = wr_val_i && (!w_full || rd_val_i);

   // Storage is not reset: contents are only observable after being written.
   always_ff @(posedge clk) begin
      if (w_wr_acc) r_mem[r_wr_ptr] <= wr_dat_i;
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_rd_val <= 1'b0;
         r_rd_dat <= '0;
      end else begin
         r_rd_val <= rd_val_i;
         if (w_wr_acc) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_rd_acc) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_rd_dat <= r_mem[r_rd_ptr];
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_cnt <= r_cnt + CNT_ONE;
            2'b01:   r_cnt <= r_cnt - CNT_ONE;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign wr_ful_o = w_full;
   assign rd_ept_o = w_empty;
   assign wd_usd_o = r_cnt;
   assign rd_val_o = r_rd_val;
   assign rd_dat_o = r_rd_dat;

`ifdef SIM_KNOB_DBG
   always @(posedge clk) begin
      if (!rstn && ((wr_val_i && wr_ful_o) || (rd_val_i && rd_ept_o))) begin
         $error("fifo_sc_ew_req_reg_based_core: write while full or read while empty");
         $finish;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_sc_ew_req_reg_based_core.sv
// -----------------------------------------------------------------------------
// tb_fifo_sc_ew_req_reg_based_core
// Two instances share clock and reset: u_dut_a (SIZE=4) for the directed and
// random traffic, u_dut_b (SIZE=3) for non-power-of-two wrap-around.
// Drivers push the expected read data into exp_q_a / exp_q_b when a read is
// issued; a monitor per instance pops and compares on each rd_val_o.
// -----------------------------------------------------------------------------
module tb_fifo_sc_ew_req_reg_based_core;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rstn;

   logic          wr_val_a, rd_val_a, wr_ful_a, rd_vo_a, rd_ept_a;
   logic [DW-1:0] wr_dat_a, rd_dat_a;
   logic [2:0]    usd_a;

   logic          wr_val_b, rd_val_b, wr_ful_b, rd_vo_b, rd_ept_b;
   logic [DW-1:0] wr_dat_b, rd_dat_b;
   logic [2:0]    usd_b;

   logic [DW-1:0] exp_q_a[$];
   logic [DW-1:0] exp_q_b[$];
   logic [DW-1:0] model_q[$];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fifo_sc_ew_req_reg_based_core #(.SIZE(4), .DATA_WD(DW)) u_dut_a (
      .clk(clk), .rstn(rstn),
      .wr_val_i(wr_val_a), .wr_dat_i(wr_dat_a), .wr_ful_o(wr_ful_a),
      .rd_val_i(rd_val_a), .rd_val_o(rd_vo_a), .rd_dat_o(rd_dat_a),
      .rd_ept_o(rd_ept_a), .wd_usd_o(usd_a)
   );

   fifo_sc_ew_req_reg_based_core #(.SIZE(3), .DATA_WD(DW)) u_dut_b (
      .clk(clk), .rstn(rstn),
      .wr_val_i(wr_val_b), .wr_dat_i(wr_dat_b), .wr_ful_o(wr_ful_b),
      .rd_val_i(rd_val_b), .rd_val_o(rd_vo_b), .rd_dat_o(rd_dat_b),
      .rd_ept_o(rd_ept_b), .wd_usd_o(usd_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic step_a(input logic wr, input logic [DW-1:0] wd,
                         input logic rd, input logic [DW-1:0] ed);
      wr_val_a = wr; wr_dat_a = wd; rd_val_a = rd;
      if (rd) exp_q_a.push_back(ed);
      @(posedge clk); #1;
      wr_val_a = 1'b0; rd_val_a = 1'b0;
   endtask

   task automatic step_b(input logic wr, input logic [DW-1:0] wd,
                         input logic rd, input logic [DW-1:0] ed);
      wr_val_b = wr; wr_dat_b = wd; rd_val_b = rd;
      if (rd) exp_q_b.push_back(ed);
      @(posedge clk); #1;
      wr_val_b = 1'b0; rd_val_b = 1'b0;
   endtask

   task automatic chk_a(input string tag, input logic [2:0] u, input logic f, input logic e);
      chk({tag, "_usd"}, 32'(usd_a), 32'(u));
      chk({tag, "_ful"}, 32'(wr_ful_a), 32'(f));
      chk({tag, "_ept"}, 32'(rd_ept_a), 32'(e));
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (rd_vo_a === 1'b1) begin
         if (exp_q_a.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_unexpected_a actual=rd_val_o=1 data=%0h required=no response", rd_dat_a);
         end else begin
            logic [DW-1:0] e;
            e = exp_q_a.pop_front();
            chk("rd_dat_a", 32'(rd_dat_a), 32'(e));
         end
      end
      if (rd_vo_b === 1'b1) begin
         if (exp_q_b.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_unexpected_b actual=rd_val_o=1 data=%0h required=no response", rd_dat_b);
         end else begin
            logic [DW-1:0] e;
            e = exp_q_b.pop_front();
            chk("rd_dat_b", 32'(rd_dat_b), 32'(e));
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [DW-1:0] wrap_vec [9] = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3,
                                   8'hC1, 8'hC2, 8'hC3};

   initial begin
      rstn = 1'b1;
      wr_val_a = 1'b0; rd_val_a = 1'b0; wr_dat_a = '0;
      wr_val_b = 1'b0; rd_val_b = 1'b0; wr_dat_b = '0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b0;

      // reset state
      chk_a("reset", 3'd0, 1'b0, 1'b1);
      chk("reset_rd_val", 32'(rd_vo_a), 32'd0);
      chk("reset_rd_dat", 32'(rd_dat_a), 32'd0);
      chk("reset_usd_b", 32'(usd_b), 32'd0);

      // fill to full
      step_a(1, 8'h11, 0, 0);
      step_a(1, 8'h22, 0, 0);
      step_a(1, 8'h33, 0, 0);
      step_a(1, 8'h44, 0, 0);
      chk_a("fill", 3'd4, 1'b1, 1'b0);

      // write while full without read: dropped
      step_a(1, 8'h55, 0, 0);
      chk_a("drop", 3'd4, 1'b1, 1'b0);

      // drain in order
      step_a(0, 0, 1, 8'h11);
      chk_a("pop1", 3'd3, 1'b0, 1'b0);
      step_a(0, 0, 1, 8'h22);
      step_a(0, 0, 1, 8'h33);
      step_a(0, 0, 1, 8'h44);
      chk_a("drain", 3'd0, 1'b0, 1'b1);

      // read while empty: response still appears, data holds 0x44
      step_a(0, 0, 1, 8'h44);
      chk_a("rd_empty", 3'd0, 1'b0, 1'b1);

      // write+read while empty: read rejected (data holds), write accepted
      step_a(1, 8'h66, 1, 8'h44);
      chk_a("wr_rd_empty", 3'd1, 1'b0, 1'b0);

      // two stored, simultaneous read/write keeps count
      step_a(1, 8'h77, 0, 0);
      step_a(1, 8'h88, 1, 8'h66);
      chk_a("rw2_a", 3'd2, 1'b0, 1'b0);
      step_a(1, 8'h99, 1, 8'h77);
      chk_a("rw2_b", 3'd2, 1'b0, 1'b0);

      // full, simultaneous read/write both accepted
      step_a(1, 8'hAA, 0, 0);
      step_a(1, 8'hBB, 0, 0);
      step_a(1, 8'hCC, 1, 8'h88);
      chk_a("rw_full", 3'd4, 1'b1, 1'b0);
      step_a(0, 0, 1, 8'h99);
      step_a(0, 0, 1, 8'hAA);
      step_a(0, 0, 1, 8'hBB);
      step_a(0, 0, 1, 8'hCC);
      chk_a("drain2", 3'd0, 1'b0, 1'b1);

      // reset with 3 entries stored and a read issued on the reset edge
      step_a(1, 8'h01, 0, 0);
      step_a(1, 8'h02, 0, 0);
      step_a(1, 8'h03, 0, 0);
      chk_a("pre_rst", 3'd3, 1'b0, 1'b0);
      rstn = 1'b1; rd_val_a = 1'b1;
      @(posedge clk); #1;
      rstn = 1'b0; rd_val_a = 1'b0;
      chk("mid_rst_rd_val", 32'(rd_vo_a), 32'd0);
      chk("mid_rst_rd_dat", 32'(rd_dat_a), 32'd0);
      chk_a("mid_rst", 3'd0, 1'b0, 1'b1);
      step_a(0, 0, 0, 0);
      chk("post_rst_rd_val", 32'(rd_vo_a), 32'd0);

      // SIZE=3: offset pointers by one, then fill/drain three times
      step_b(1, 8'h5A, 0, 0);
      step_b(0, 0, 1, 8'h5A);
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 3; i++) step_b(1, wrap_vec[r*3+i], 0, 0);
         chk("wrap_full_usd", 32'(usd_b), 32'd3);
         chk("wrap_full_ful", 32'(wr_ful_b), 32'd1);
         for (int i = 0; i < 3; i++) step_b(0, 0, 1, wrap_vec[r*3+i]);
         chk("wrap_empty_ept", 32'(rd_ept_b), 32'd1);
      end

      // random legal traffic on SIZE=4 against a queue model
      model_q.delete();
      for (int c = 0; c < 10000; c++) begin
         logic          wr, rd;
         logic [DW-1:0] wd, ed;
         rd = ($urandom_range(0, 1) == 1) && (model_q.size() > 0);
         wr = ($urandom_range(0, 1) == 1) && (model_q.size() < 4);
         wd = 8'($urandom_range(0, 255));
         ed = '0;
         if (rd) ed = model_q.pop_front();
         if (wr) model_q.push_back(wd);
         step_a(wr, wd, rd, ed);
         chk("rand_usd", 32'(usd_a), 32'(model_q.size()));
      end

      repeat (3) @(posedge clk);
      #1;
      chk("exp_q_a_empty", 32'(exp_q_a.size()), 32'd0);
      chk("exp_q_b_empty", 32'(exp_q_b.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_sc_ew_req_reg_based_core.md
FIFO_SC_EW_REQ_REG_BASED_CORE -- requirements
Module: fifo_sc_ew_req_reg_based

Interface
REQ-001 Parameter SIZE, default 8, FIFO depth in entries, SHALL be >= 2 (any integer, not only powers of two).
REQ-002 Parameter DATA_WD, default 32, entry width in bits.
REQ-003 Derived SIZE_WD = ceil(log2(SIZE)), computed from the shared log2 function, not a port-level parameter.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rstn  input  1  reset; one clock, reset is synchronous and active-high (rstn=1 resets on the clk edge; the port name follows the codebase convention).
REQ-006 wr_val_i  input  1  write request; wr_dat_i is pushed on this edge.
REQ-007 wr_dat_i  input  DATA_WD  write data.
REQ-008 wr_ful_o  output  1  full flag, combinational: wd_usd_o >= SIZE.
REQ-009 rd_val_i  input  1  read request; pops the head entry on this edge.
REQ-010 rd_val_o  output  1  read response valid, registered copy of rd_val_i (1-cycle latency).
REQ-011 rd_dat_o  output  DATA_WD  read data, registered; valid when rd_val_o=1.
REQ-012 rd_ept_o  output  1  empty flag, combinational: wd_usd_o == 0.
REQ-013 wd_usd_o  output  SIZE_WD+1  number of stored entries, 0..SIZE, registered.

Function
REQ-014 Storage SHALL be SIZE registers of DATA_WD bits, with a write pointer, a read pointer and an occupancy counter; pointers wrap from SIZE-1 to 0.
REQ-015 Write accepted (wr_val_i=1, not full): on the edge, store wr_dat_i at the write pointer, advance it, count +1.
REQ-016 Read accepted (rd_val_i=1, not empty): on the same edge, load rd_dat_o with the head entry, advance the read pointer, count -1.
REQ-017 Read latency: rd_val_o and rd_dat_o SHALL both be presented exactly one cycle after the rd_val_i cycle.
REQ-018 wd_usd_o, wr_ful_o and rd_ept_o SHALL reflect the pop on the cycle after the request, i.e. the same cycle as rd_val_o.
REQ-019 Simultaneous accepted read and write: both take effect and the count is unchanged.
REQ-020 When the FIFO is full, a simultaneous read and write SHALL both be accepted.
REQ-021 When the FIFO is empty, a simultaneous write and read: the read is rejected, because data written this edge is readable from the next cycle on; the write is accepted.
REQ-022 Write while full, without a read: data is dropped; pointers and count are unchanged.
REQ-023 Read while empty: pointers and count are unchanged, rd_dat_o holds its previous value, and rd_val_o still asserts one cycle later.
REQ-024 rd_dat_o SHALL hold its value in cycles with no accepted read.
REQ-025 Write data SHALL be returned in strict FIFO order with no reordering or duplication.
REQ-026 Under the SIM_KNOB_DBG define, the simulation SHALL report an error and finish when wr_val_i&&wr_ful_o or rd_val_i&&rd_ept_o is sampled high at a clock edge.

Reset
REQ-027 While rstn=1 at a clock edge, the block SHALL clear both pointers, the count, rd_val_o and rd_dat_o to 0.
REQ-028 Storage registers need not be reset.
REQ-029 After reset, outputs SHALL be wr_ful_o=0, rd_ept_o=1, wd_usd_o=0.
REQ-030 Reset asserted mid-operation SHALL discard all contents, and any read response in flight SHALL not appear.

Structure
REQ-031 The log2 function (FUNC_LOG2 equivalent) SHALL come from the shared package or define file; the block defines no typedefs.
REQ-032 The block SHALL be a single flat module with no sub-modules.
REQ-033 Pointer-increment-with-wrap logic SHALL be shared between the write and read pointers.

Verification
REQ-034 SIZE=4, DATA_WD=8: write 0x11,0x22,0x33,0x44 on consecutive cycles -> wd_usd_o=4, wr_ful_o=1; then read 4 cycles -> rd_val_o pulses one cycle later with 0x11,0x22,0x33,0x44, ending with rd_ept_o=1.
REQ-035 With 2 entries stored, read and write in the same cycle -> wd_usd_o stays 2 and order is preserved.
REQ-036 With the FIFO full, write 0x55 without a read -> dropped, wd_usd_o=4, and the next reads return the original data.
REQ-037 Fill and drain 3 times with SIZE=3 -> pointer wrap-around returns correct data every time.
REQ-038 Assert reset with 3 entries stored and a read pending -> next cycle rd_val_o=0, rd_dat_o=0, wd_usd_o=0, rd_ept_o=1.
REQ-039 Random wr/rd traffic, 10k cycles, never violating full/empty, checked against a scoreboard -> zero mismatches and wd_usd_o always equal to the model count.
